// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
//   CALC_W       default binary operand width
//   CALC_DIGITS  default number of packed BCD digits
//   state_t      converter sequencing states
//   bcd_digit_t  one packed BCD digit
package calc_pkg;

  localparam int unsigned CALC_W      = 16;
  localparam int unsigned CALC_DIGITS = 5;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
//   digit_in   BCD digit before correction
//   digit_out  corrected digit (4-bit add, no carry out)
module bcd_digit_adj
  import calc_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
//   clk      system clock
//   reset    synchronous active-high reset, aborts any conversion
//   start    conversion request, only honoured while idle
//   bin_in   operand, captured on the accepted start
//   busy     conversion in progress
//   done     one-cycle pulse when bcd_out/neg/ovf4 take a new result
//   bcd_out  packed BCD result, digit 0 in bits [3:0]
//   neg      sign of the converted operand (0 unless SIGNED)
//   ovf4     result needs more than the four display digits
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last conversion
// CONV  | shifting one operand bit per clock into the BCD accumulator
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int unsigned W      = CALC_W,
  parameter int unsigned DIGITS = CALC_DIGITS,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  ovf4
);

  localparam int unsigned   CW        = $clog2(W + 1);
  localparam int unsigned   BW        = 4 * DIGITS;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mag_q, mag_d;
  logic [BW-1:0] acc_q, acc_d;
  logic          pend_neg_q, pend_neg_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic          neg_q, neg_d;
  logic          ovf4_q, ovf4_d;
  logic          done_q, done_d;

  logic          in_neg;
  logic [W-1:0]  in_mag;
  logic [BW-1:0] acc_adj;
  logic [BW:0]   shift_full;
  logic          ovf_hi;

  // The most negative input negates to itself as a bit pattern, which read
  // unsigned is exactly its magnitude, so no extra width is needed.
  assign in_neg = SIGNED && bin_in[W-1];
  assign in_mag = in_neg ? (~bin_in + W'(1)) : bin_in;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (acc_q[4*g +: 4]),
      .digit_out (acc_adj[4*g +: 4])
    );
  end

  assign shift_full = {acc_adj, mag_q[W-1]};

  // The bit shifted out of the top digit is folded into ovf4; it is always
  // zero when DIGITS covers the full operand range.
  if (DIGITS > 4) begin : g_ovf
    assign ovf_hi = |shift_full[BW:16];
  end else begin : g_no_ovf
    assign ovf_hi = shift_full[BW];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    acc_d      = acc_q;
    pend_neg_d = pend_neg_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    ovf4_d     = ovf4_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CONV;
          mag_d      = in_mag;
          pend_neg_d = in_neg;
          acc_d      = '0;
          cnt_d      = '0;
        end
      end
      CONV: begin
        acc_d = shift_full[BW-1:0];
        mag_d = {mag_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = IDLE;
          cnt_d   = '0;
          bcd_d   = shift_full[BW-1:0];
          neg_d   = pend_neg_q;
          ovf4_d  = ovf_hi;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      acc_q      <= '0;
      pend_neg_q <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      ovf4_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      acc_q      <= acc_d;
      pend_neg_q <= pend_neg_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      ovf4_q     <= ovf4_d;
      done_q     <= done_d;
    end
  end

  assign busy    = (state_q == CONV);
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign neg     = neg_q;
  assign ovf4    = ovf4_q;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Multi-cycle binary-to-BCD converter using the shift-add-3 (double-dabble) method.
- Sits between the arithmetic unit and the LCD controller. It takes the 16-bit binary result and produces packed BCD digits for display.
- Start/busy/done handshake; one iteration per clock, so no wide combinational chain.
- Optional two's-complement input with a sign flag, so negative subtraction results display correctly.

Parameters:
- W, 16, binary input width in bits.
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^W.
- SIGNED, 0, when 1 bin_in is two's complement and the magnitude is converted.

Ports:
- clk  input  1  system clock (50 MHz domain).
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- bin_in  input  W  value to convert; sampled on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out/neg/ovf4 are updated.
- bcd_out  output  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- neg  output  1  sign of the converted value (always 0 when SIGNED=0).
- ovf4  output  1  high when any digit above digit 3 is nonzero (value > 9999; does not fit the 4-digit display).

Behaviour:
- Reset: state=IDLE; busy=0, done=0, bcd_out=0, neg=0, ovf4=0; shift register and counter cleared. Reset mid-conversion aborts it: no done pulse, outputs forced to reset values.
- States:
  - IDLE: busy=0. On start=1, latch operands and go to CONV.
  - CONV: busy=1; one iteration per clock.
  - IDLE again after the final iteration.
- Accept (edge k, IDLE and start=1):
  - mag = bin_in. If SIGNED=1 and bin_in[W-1]=1, mag = (~bin_in + 1) taken as an unsigned W-bit value; -2^(W-1) converts to magnitude 2^(W-1).
  - Pending sign = (SIGNED && bin_in[W-1]).
  - BCD accumulator = 0; iteration counter = 0; busy goes to 1 after edge k.
- Iteration (edges k+1 .. k+W):
  - Every accumulator digit >= 5 gets +3 (4-bit add, no carry out of the digit).
  - Then {accumulator, mag} shifts left by 1.
  - Counter increments.
- Final iteration (edge k+W):
  - bcd_out = corrected-and-shifted accumulator; neg = pending sign.
  - ovf4 = |bcd_out[4*DIGITS-1:16].
  - done=1 for exactly one cycle; busy=0; state=IDLE.
  - Latency: start sampled at edge k, done visible in the cycle after edge k+W (16 cycles for W=16).
- start while busy=1 is ignored and not queued. start in the done cycle (already IDLE) is accepted, giving a back-to-back conversion.
- bin_in changing during CONV has no effect.
- bcd_out/neg/ovf4 hold their previous values until the next done; they are never partially updated.
- Negative zero cannot occur. Input 0 gives neg=0.

Decomposition:
- Package calc_pkg:
  - Constants CALC_W=16 and CALC_DIGITS=5.
  - State enum {IDLE, CONV}.
  - BCD digit type (4-bit).
- Sub-module bcd_digit_adj: combinational single-digit correction, out = (in >= 5) ? in + 3 : in, instantiated DIGITS times via generate.
- Counter width = clog2(W+1).

Test Plan:
- SIGNED=0, bin_in=0, start pulse -> done exactly 16 cycles after the start edge; bcd_out=0x00000, neg=0, ovf4=0; busy high for the 16 cycles before done.
- SIGNED=0, bin_in=9999 then 10000 -> bcd_out=0x09999 with ovf4=0, then 0x10000 with ovf4=1; 65535 -> 0x65535, ovf4=1.
- SIGNED=1, bin_in=0xFFF6 (-10) -> bcd_out=0x00010, neg=1. 0x8000 -> bcd_out=0x32768, neg=1, ovf4=1. 0x007B -> 0x00123, neg=0.
- Extra start pulses while busy, plus bin_in changed mid-CONV -> exactly one done; result matches the originally latched value.
- Start asserted in the done cycle with bin_in=42 -> accepted; second done 16 cycles later with bcd_out=0x00042.
- reset asserted at iteration 7 -> next cycle busy=0, bcd_out=0, no done. A new start after release converts correctly.
